// File: rtl/farrow_resampler.sv
// rtl/farrow_resampler.sv - cubic-Lagrange Farrow resampler, shared-multiplier Horner, valid/ready streams
// Build option: define FARROW_ROUND_EN for round-half-up Horner shifts; default build truncates.
module farrow_resampler #(
  parameter int DW = 8,
  parameter int FW = 8,
  parameter int OW = DW + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] x_in,
  input  logic                 x_valid,
  output logic                 x_ready,
  input  logic [FW-1:0]        delta,
  output logic signed [OW-1:0] y_out,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [FW-1:0]        mu_out
);

  localparam int CW = DW + 3;       // coefficient and Horner intermediate width
  localparam int KW = DW + 9;       // headroom for the 85x / 43x coefficient products
  localparam int PW = CW + FW + 1;  // shared multiplier product width

  localparam logic signed [KW-1:0] K85  = KW'(85);
  localparam logic signed [KW-1:0] K43  = KW'(43);
  localparam logic signed [CW-1:0] YMAX = CW'((1 << (OW - 1)) - 1);
  localparam logic signed [CW-1:0] YMIN = CW'(-(1 << (OW - 1)));
`ifdef FARROW_ROUND_EN
  localparam logic signed [PW-1:0] HALF = PW'(1) << (FW - 1);
`endif

  typedef enum logic [2:0] {FILL, COEF, H1, H2, H3, EMIT} state_t;

  state_t               state_q;
  logic signed [DW-1:0] tap_q [4];
  logic signed [CW-1:0] c0_q, c1_q, c2_q, c3_q;
  logic signed [CW-1:0] acc_q;
  logic [FW-1:0]        mu_q;
  logic [2:0]           need_q;
  logic signed [OW-1:0] y_out_q;

  // Taps sign-extended so the coefficient products cannot overflow
  logic signed [KW-1:0] k0, k1, k2, k3;
  assign k0 = {{(KW-DW){tap_q[0][DW-1]}}, tap_q[0]};
  assign k1 = {{(KW-DW){tap_q[1][DW-1]}}, tap_q[1]};
  assign k2 = {{(KW-DW){tap_q[2][DW-1]}}, tap_q[2]};
  assign k3 = {{(KW-DW){tap_q[3][DW-1]}}, tap_q[3]};

  // Select Horner operands for the single shared multiplier
  logic signed [CW-1:0] h_mul_a, h_add;
  always_comb begin
    h_mul_a = c3_q;
    h_add   = c2_q;
    case (state_q)
      H2: begin
        h_mul_a = acc_q;
        h_add   = c1_q;
      end
      H3: begin
        h_mul_a = acc_q;
        h_add   = c0_q;
      end
      default: ;
    endcase
  end

  // mu is a non-negative fraction, so it enters the signed multiply zero-extended
  logic signed [FW:0]   mu_x;
  logic signed [PW-1:0] prod;
  logic signed [CW-1:0] h_res;
  assign mu_x = {1'b0, mu_q};
  assign prod = h_mul_a * mu_x;
`ifdef FARROW_ROUND_EN
  assign h_res = h_add + CW'((prod + HALF) >>> FW);
`else
  assign h_res = h_add + CW'(prod >>> FW);
`endif

  // Clamp the final Horner result into the output range
  logic signed [OW-1:0] y_sat;
  always_comb begin
    y_sat = h_res[OW-1:0];
    if (h_res > YMAX) begin
      y_sat = YMAX[OW-1:0];
    end else if (h_res < YMIN) begin
      y_sat = YMIN[OW-1:0];
    end
  end

  // Phase advance; the top bit is the carry into the next input sample
  logic [FW:0] mu_sum_d;
  assign mu_sum_d = {1'b0, mu_q} + {1'b0, delta};

  assign x_ready = (state_q == FILL) && !reset;
  assign y_valid = (state_q == EMIT);
  assign y_out   = y_out_q;
  assign mu_out  = mu_q;

  // Sequencer: fill taps, build coefficients, three Horner steps, then hold the result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      for (int i = 0; i < 4; i++) begin
        tap_q[i] <= '0;
      end
      c0_q    <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      c3_q    <= '0;
      acc_q   <= '0;
      mu_q    <= '0;
      need_q  <= 3'd4;
      y_out_q <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (x_valid) begin
            tap_q[0] <= tap_q[1];
            tap_q[1] <= tap_q[2];
            tap_q[2] <= tap_q[3];
            tap_q[3] <= x_in;
            need_q   <= need_q - 3'd1;
            if (need_q == 3'd1) begin
              state_q <= COEF;
            end
          end
        end
        COEF: begin
          c0_q    <= CW'(k1);
          c1_q    <= CW'((-(K85 * k0) >>> 8) - (k1 >>> 1) + k2 - ((K43 * k3) >>> 8));
          c2_q    <= CW'(((k0 + k2) >>> 1) - k1);
          c3_q    <= CW'(((k1 - k2) >>> 1) + ((K43 * (k3 - k0)) >>> 8));
          state_q <= H1;
        end
        H1: begin
          acc_q   <= h_res;
          state_q <= H2;
        end
        H2: begin
          acc_q   <= h_res;
          state_q <= H3;
        end
        H3: begin
          y_out_q <= y_sat;
          state_q <= EMIT;
        end
        EMIT: begin
          if (y_ready) begin
            mu_q <= mu_sum_d[FW-1:0];
            if (mu_sum_d[FW]) begin
              need_q  <= 3'd1;
              state_q <= FILL;
            end else begin
              state_q <= H1;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule

// File: doc/farrow_resampler.md
# farrow_resampler

Parametrised cubic-Lagrange Farrow fractional resampler with a programmable phase step and valid/ready streaming on both sides. It replaces fixed-ratio, fixed-count Farrow blocks in the multirate chain. Coefficients are computed once per consumed input sample. Horner evaluation is time-multiplexed over one shared multiplier. The output rate is set at run time by `delta`.

## Interface
- `DW`, 8: input sample width, signed.
- `FW`, 8: fractional phase width; `mu` and `delta` are in units of 2^-FW input samples.
- `OW`, DW+1: output width, signed, saturated.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `x_in` in DW: input sample, signed.
- `x_valid` in 1: `x_in` is valid.
- `x_ready` out 1: block accepts a sample this cycle.
- `delta` in FW: phase step per output, unsigned. Sampled at each output handshake.
- `y_out` out OW: resampled output, signed.
- `y_valid` out 1: `y_out` is valid.
- `y_ready` in 1: downstream accepts `y_out`.
- `mu_out` out FW: current fractional phase, for debug.

## Operation
- Taps `x[0..3]`, with `x[0]` oldest. An accept shifts `x[i-1] <= x[i]` and `x[3] <= x_in`. `mu` is the delay from `x[1]` toward `x[2]`.
- FSM states: FILL, COEF, H1, H2, H3, EMIT. Each non-FILL, non-EMIT state lasts exactly one cycle.
- FILL: `x_ready` = 1. An accept happens when `x_valid` = 1 and decrements `need`.
  - After reset, `need` = 4. After a carry, `need` = 1.
  - The state moves to COEF on the accept that brings `need` to 0.
- COEF: computes the following, all at width DW+3 with `>>>` as arithmetic shift:
  - `c0 = x[1]`
  - `c1 = (-85*x[0] >>> 8) - (x[1] >>> 1) + x[2] - (43*x[3] >>> 8)`
  - `c2 = ((x[0]+x[2]) >>> 1) - x[1]`
  - `c3 = ((x[1]-x[2]) >>> 1) + (43*(x[3]-x[0]) >>> 8)`
- Horner steps, using one signed multiplier of width (DW+3)×(FW+1) with `mu` zero-extended:
  - H1: `y1 = c2 + (c3*mu >>> FW)`
  - H2: `y2 = c1 + (y1*mu >>> FW)`
  - H3: `y3 = c0 + (y2*mu >>> FW)`. `y3` is saturated to OW bits and registered into `y_out`.
  - Intermediates are DW+3 bits wide.
- EMIT: `y_valid` = 1. `y_out` and `mu` are held until `y_ready` = 1. On the handshake:
  - Compute `s = mu + delta`, at FW+1 bits.
  - If `s[FW]` = 1: `mu <= s - 2^FW`, `need` = 1, go to FILL.
  - Otherwise: `mu <= s`, go to H1. The coefficients are reused.
- `delta` = 0: `mu` never advances. Every output equals the current `c0` value (saturated). No further input is consumed.
- Reset at any time, including mid-Horner or in EMIT:
  - State goes to FILL, taps to 0, `mu` to 0, `need` to 4.
  - Any partial result is discarded.

## Timing
- Reset values: `x_ready`=0 while reset is asserted, then 1 in the first FILL cycle. `y_valid`=0, `y_out`=0, `mu_out`=0.
- After the completing accept edge, `y_valid` rises 4 edges later (COEF, H1, H2, H3).
- After an EMIT handshake with no carry, the next `y_valid` rises 3 edges later. Peak throughput is 1 output per 4 cycles.
- `x_ready` and `y_valid` are never high in the same cycle.
- `y_out` changes only on the H3→EMIT edge.

## Configuration
- `FARROW_ROUND_EN` defined: each Horner shift becomes `(p + 2^(FW-1)) >>> FW`, i.e. round half up.
- `FARROW_ROUND_EN` undefined: plain truncating `>>>`.
- COEF arithmetic is identical in both builds.
- All test values below assume the macro is undefined.

## Test plan
- Reset with `y_ready`=1 -> `y_valid`=0, `y_out`=0, `mu_out`=0. `x_ready`=1 in the first cycle after release.
- Constant 50 input, `delta`=64 -> every output is 50. Exactly 4 outputs per consumed sample after fill. `mu_out` cycles 0, 64, 128, 192.
- Ramp input 0, 16, 32, 48, 64, …, `delta`=128 -> outputs 16, 24, 32, 40, 48, …. First `y_valid` is 4 cycles after the 4th accept.
- Hold `y_ready`=0 for 10 cycles in EMIT -> `y_out` and `mu_out` stay stable, and `x_ready` stays 0.
- `delta`=0 after fill with 0, 16, 32, 48 -> 20 consecutive outputs, all 16. `x_ready` is never reasserted.
- Assert `reset` during H2 -> `y_valid`=0 immediately. The next output requires 4 fresh accepts, and the taps read 0 before that.
